// File: rtl/uart_fifo.sv
// -----------------------------------------------------------------------------
// uart_fifo
//
// Serial port between the CPU port decoder and the RS232 pins. It has one
// transmit holding stage, a receiver with majority-vote bit sampling, and a
// receive FIFO that drives a level-based RTS.
//
// The baud divisor, parity mode and stop-bit count are set at runtime. Each
// frame latches them when it starts, so changing them mid-frame has no effect
// on that frame. A bit period is max(divisor,15)+1 cycles of clk_bus.
//
// Ports:
//   clk_bus        system clock; all logic runs on the rising edge
//   rst_n          asynchronous active-low reset
//   divisor        bit period minus one, in clk_bus cycles (values < 15 act as 15)
//   cfg_parity_en  1 = a parity bit follows the data
//   cfg_parity_odd 1 = odd parity, 0 = even parity
//   cfg_stop2      1 = two stop bits on TX (RX checks only the first stop bit)
//   txdata         byte to send; latched when the request is accepted
//   txbegin        send request, sampled as a level
//   txbusy         transmitter busy
//   rxdata         FIFO head, first-word fall-through (0 when the FIFO is empty)
//   rx_valid       FIFO not empty
//   data_read      one-cycle pop strobe; ignored when the FIFO is empty
//   rx_count       FIFO fill level, 0 .. 2**FIFO_AW
//   rx_overrun     sticky: a byte was lost because the FIFO was full
//   rx_frame_err   sticky: the first stop bit was sampled as 0
//   rx_parity_err  sticky: the parity bit did not match the data
//   err_clr        clears all three sticky flags
//   rx             serial input, asynchronous to clk_bus
//   tx             serial output
//   rts            1 = the peer must pause (fill level at or above RTS_THRESH)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_fifo #(
    parameter int DIV_W      = 16,
    parameter int FIFO_AW    = 4,
    parameter int RTS_THRESH = 12
) (
    input  logic               clk_bus,
    input  logic               rst_n,
    input  logic [DIV_W-1:0]   divisor,
    input  logic               cfg_parity_en,
    input  logic               cfg_parity_odd,
    input  logic               cfg_stop2,
    input  logic [7:0]         txdata,
    input  logic               txbegin,
    output logic               txbusy,
    output logic [7:0]         rxdata,
    output logic               rx_valid,
    input  logic               data_read,
    output logic [FIFO_AW:0]   rx_count,
    output logic               rx_overrun,
    output logic               rx_frame_err,
    output logic               rx_parity_err,
    input  logic               err_clr,
    input  logic               rx,
    output logic               tx,
    output logic               rts
);

    localparam int                 DEPTH     = 2 ** FIFO_AW;
    localparam logic [DIV_W-1:0]   MIN_DIV   = DIV_W'(15);
    localparam logic [DIV_W-1:0]   CNT_ONE   = DIV_W'(1);
    localparam logic [DIV_W:0]     HALF_ONE  = (DIV_W + 1)'(1);
    localparam logic [FIFO_AW:0]   COUNT_ONE = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW:0]   COUNT_MAX = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0]   COUNT_RTS = (FIFO_AW + 1)'(RTS_THRESH);
    localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_e;

    // Clamp the divisor. The receiver needs room for three vote samples
    // around mid-bit, so the bit period is never shorter than 16 cycles.
    logic [DIV_W-1:0] div_eff;
    assign div_eff = (divisor < MIN_DIV) ? MIN_DIV : divisor;

    // =========================================================================
    // Transmitter
    // =========================================================================
    state_e           tx_state_q;
    logic [DIV_W-1:0] tx_div_q;
    logic [DIV_W-1:0] tx_cnt_q;
    logic [7:0]       tx_shift_q;
    logic [2:0]       tx_bit_q;
    logic             tx_par_en_q;
    logic             tx_par_bit_q;
    logic             tx_stop2_q;
    logic             tx_stop_second_q;
    logic             tx_q;
    logic             txbusy_q;
    logic             tx_cnt_done;

    assign tx_cnt_done = (tx_cnt_q == tx_div_q);

    // NOTE: state registers are written with non-blocking assignments only,
    // so every always_ff reads the pre-edge values regardless of block order.
    always_ff @(posedge clk_bus or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q       <= ST_IDLE;
            tx_div_q         <= MIN_DIV;
            tx_cnt_q         <= '0;
            tx_shift_q       <= '0;
            tx_bit_q         <= '0;
            tx_par_en_q      <= 1'b0;
            tx_par_bit_q     <= 1'b0;
            tx_stop2_q       <= 1'b0;
            tx_stop_second_q <= 1'b0;
            tx_q             <= 1'b1;
            txbusy_q         <= 1'b0;
        end else begin
            unique case (tx_state_q)
                ST_IDLE: begin
                    tx_q     <= 1'b1;
                    tx_cnt_q <= '0;
                    if (txbegin && !txbusy_q) begin
                        tx_shift_q   <= txdata;
                        tx_div_q     <= div_eff;
                        tx_par_en_q  <= cfg_parity_en;
                        tx_par_bit_q <= (^txdata) ^ cfg_parity_odd;
                        tx_stop2_q   <= cfg_stop2;
                        tx_q         <= 1'b0;
                        txbusy_q     <= 1'b1;
                        tx_state_q   <= ST_START;
                    end
                end
                ST_START: begin
                    if (tx_cnt_done) begin
                        tx_cnt_q   <= '0;
                        tx_bit_q   <= '0;
                        tx_q       <= tx_shift_q[0];
                        tx_state_q <= ST_DATA;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + CNT_ONE;
                    end
                end
                ST_DATA: begin
                    if (tx_cnt_done) begin
                        tx_cnt_q <= '0;
                        if (tx_bit_q == 3'd7) begin
                            tx_stop_second_q <= 1'b0;
                            if (tx_par_en_q) begin
                                tx_q       <= tx_par_bit_q;
                                tx_state_q <= ST_PARITY;
                            end else begin
                                tx_q       <= 1'b1;
                                tx_state_q <= ST_STOP;
                            end
                        end else begin
                            // The shift register always presents the current bit in [0].
                            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                            tx_q       <= tx_shift_q[1];
                            tx_bit_q   <= tx_bit_q + 3'd1;
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + CNT_ONE;
                    end
                end
                ST_PARITY: begin
                    if (tx_cnt_done) begin
                        tx_cnt_q   <= '0;
                        tx_q       <= 1'b1;
                        tx_state_q <= ST_STOP;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + CNT_ONE;
                    end
                end
                ST_STOP: begin
                    if (tx_cnt_done) begin
                        tx_cnt_q <= '0;
                        if (tx_stop2_q && !tx_stop_second_q) begin
                            tx_stop_second_q <= 1'b1;
                        end else begin
                            // busy drops on the next cycle, which can accept the next frame
                            txbusy_q   <= 1'b0;
                            tx_state_q <= ST_IDLE;
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    tx_q       <= 1'b1;
                    txbusy_q   <= 1'b0;
                    tx_state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx     = tx_q;
    assign txbusy = txbusy_q;

    // =========================================================================
    // Receiver
    // =========================================================================
    // Two-flop synchroniser, plus one more flop to detect the falling edge.
    // All three reset to the idle line level so that releasing reset never
    // looks like a start bit.
    logic rx_meta_q;
    logic rx_sync_q;
    logic rx_prev_q;

    always_ff @(posedge clk_bus or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    state_e           rx_state_q;
    logic [DIV_W-1:0] rx_div_q;
    logic [DIV_W:0]   rx_half_q;
    logic [DIV_W-1:0] rx_cnt_q;
    logic [7:0]       rx_shift_q;
    logic [2:0]       rx_bit_q;
    logic             rx_par_en_q;
    logic             rx_par_odd_q;
    logic [1:0]       rx_vote_q;

    logic [DIV_W:0]   rx_cnt_ext;
    logic             rx_at_s0;
    logic             rx_at_s1;
    logic             rx_at_eval;
    logic             rx_cnt_done;
    logic             rx_maj;
    logic             rx_push;
    logic             frame_err_ev;
    logic             parity_err_ev;

    // The counter offset is measured from the first cycle of the bit.
    // Samples are taken at half-1 and half, and the vote is resolved at half+1
    // using the live third sample.
    assign rx_cnt_ext  = {1'b0, rx_cnt_q};
    assign rx_at_s0    = (rx_cnt_ext == rx_half_q - HALF_ONE);
    assign rx_at_s1    = (rx_cnt_ext == rx_half_q);
    assign rx_at_eval  = (rx_cnt_ext == rx_half_q + HALF_ONE);
    assign rx_cnt_done = (rx_cnt_q == rx_div_q);
    assign rx_maj      = (rx_vote_q[0] & rx_vote_q[1])
                       | (rx_vote_q[0] & rx_sync_q)
                       | (rx_vote_q[1] & rx_sync_q);

    assign rx_push       = (rx_state_q == ST_STOP) && rx_at_eval && rx_maj;
    assign frame_err_ev  = (rx_state_q == ST_STOP) && rx_at_eval && !rx_maj;
    assign parity_err_ev = (rx_state_q == ST_PARITY) && rx_at_eval
                         && (rx_maj != ((^rx_shift_q) ^ rx_par_odd_q));

    always_ff @(posedge clk_bus or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q   <= ST_IDLE;
            rx_div_q     <= MIN_DIV;
            rx_half_q    <= '0;
            rx_cnt_q     <= '0;
            rx_shift_q   <= '0;
            rx_bit_q     <= '0;
            rx_par_en_q  <= 1'b0;
            rx_par_odd_q <= 1'b0;
            rx_vote_q    <= 2'b11;
        end else begin
            if (rx_state_q != ST_IDLE) begin
                rx_cnt_q <= rx_cnt_q + CNT_ONE;
                if (rx_at_s0) rx_vote_q[0] <= rx_sync_q;
                if (rx_at_s1) rx_vote_q[1] <= rx_sync_q;
            end
            unique case (rx_state_q)
                ST_IDLE: begin
                    rx_cnt_q <= '0;
                    if (rx_prev_q && !rx_sync_q) begin
                        // The edge-detect cycle counts as offset 0 of the start bit.
                        rx_cnt_q     <= CNT_ONE;
                        rx_div_q     <= div_eff;
                        rx_half_q    <= ({1'b0, div_eff} + HALF_ONE) >> 1;
                        rx_par_en_q  <= cfg_parity_en;
                        rx_par_odd_q <= cfg_parity_odd;
                        rx_state_q   <= ST_START;
                    end
                end
                ST_START: begin
                    if (rx_at_eval && rx_maj) begin
                        rx_state_q <= ST_IDLE;
                    end else if (rx_cnt_done) begin
                        rx_cnt_q   <= '0;
                        rx_bit_q   <= '0;
                        rx_state_q <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (rx_at_eval) rx_shift_q <= {rx_maj, rx_shift_q[7:1]};
                    if (rx_cnt_done) begin
                        rx_cnt_q <= '0;
                        if (rx_bit_q == 3'd7) begin
                            rx_state_q <= rx_par_en_q ? ST_PARITY : ST_STOP;
                        end else begin
                            rx_bit_q <= rx_bit_q + 3'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (rx_cnt_done) begin
                        rx_cnt_q   <= '0;
                        rx_state_q <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    // Leave mid-stop so that a start edge right after this bit is caught.
                    if (rx_at_eval) rx_state_q <= ST_IDLE;
                end
                default: rx_state_q <= ST_IDLE;
            endcase
        end
    end

    // =========================================================================
    // Receive FIFO
    // =========================================================================
    logic [7:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q;
    logic [FIFO_AW-1:0] rd_ptr_q;
    logic [FIFO_AW:0]   count_q;
    logic [FIFO_AW:0]   count_d;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;
    logic               push_ok;
    logic               overrun_ev;

    assign fifo_full  = (count_q == COUNT_MAX);
    assign fifo_empty = (count_q == '0);
    assign pop        = data_read && !fifo_empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still succeeds.
    assign push_ok    = rx_push && (!fifo_full || pop);
    assign overrun_ev = rx_push && fifo_full && !pop;

    // NOTE: every variable assigned in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        count_d = count_q;
        unique case ({push_ok, pop})
            2'b10:   count_d = count_q + COUNT_ONE;
            2'b01:   count_d = count_q - COUNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // NOTE: the storage array has no reset. The pointers and count define
    // which entries are valid, and rxdata is forced to 0 while the FIFO is empty.
    always_ff @(posedge clk_bus) begin
        if (push_ok) mem_q[wr_ptr_q] <= rx_shift_q;
    end

    always_ff @(posedge clk_bus or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)     rd_ptr_q <= rd_ptr_q + PTR_ONE;
            count_q <= count_d;
        end
    end

    assign rxdata   = fifo_empty ? 8'h00 : mem_q[rd_ptr_q];
    assign rx_valid = !fifo_empty;
    assign rx_count = count_q;

    // =========================================================================
    // Sticky error flags and RTS
    // =========================================================================
    logic overrun_q, overrun_d;
    logic frame_err_q, frame_err_d;
    logic parity_err_q, parity_err_d;
    logic rts_q;

    // An error event wins over err_clr in the same cycle.
    always_comb begin
        overrun_d    = overrun_ev    ? 1'b1 : (err_clr ? 1'b0 : overrun_q);
        frame_err_d  = frame_err_ev  ? 1'b1 : (err_clr ? 1'b0 : frame_err_q);
        parity_err_d = parity_err_ev ? 1'b1 : (err_clr ? 1'b0 : parity_err_q);
    end

    always_ff @(posedge clk_bus or negedge rst_n) begin
        if (!rst_n) begin
            overrun_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            rts_q        <= 1'b0;
        end else begin
            overrun_q    <= overrun_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            // rts follows the registered count, so it lags a count change by one cycle.
            rts_q        <= (count_q >= COUNT_RTS);
        end
    end

    assign rx_overrun    = overrun_q;
    assign rx_frame_err  = frame_err_q;
    assign rx_parity_err = parity_err_q;
    assign rts           = rts_q;

endmodule

// File: tb/tb_uart_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_fifo
//
// Self-checking bench for uart_fifo. A test task per feature drives stimulus
// and compares inline. Received bytes are checked against a scoreboard queue:
// a byte is pushed when it is sent and popped when the FIFO presents it.
// Inputs change on the falling clock edge and outputs are sampled there too.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_uart_fifo;

    localparam int DIV_W      = 16;
    localparam int FIFO_AW    = 4;
    localparam int RTS_THRESH = 12;
    localparam int DEPTH      = 16;
    localparam int P          = 16;

    logic               clk_bus = 1'b0;
    logic               rst_n   = 1'b0;
    logic [DIV_W-1:0]   divisor = 16'd15;
    logic               cfg_parity_en  = 1'b0;
    logic               cfg_parity_odd = 1'b0;
    logic               cfg_stop2      = 1'b0;
    logic [7:0]         txdata    = 8'h00;
    logic               txbegin   = 1'b0;
    logic               txbusy;
    logic [7:0]         rxdata;
    logic               rx_valid;
    logic               data_read = 1'b0;
    logic [FIFO_AW:0]   rx_count;
    logic               rx_overrun;
    logic               rx_frame_err;
    logic               rx_parity_err;
    logic               err_clr   = 1'b0;
    logic               rx;
    logic               tx;
    logic               rts;

    logic               loop_en = 1'b0;
    logic               rx_drv  = 1'b1;
    assign rx = loop_en ? tx : rx_drv;

    int checks   = 0;
    int failures = 0;
    logic [7:0] sb_q[$];

    uart_fifo #(
        .DIV_W      (DIV_W),
        .FIFO_AW    (FIFO_AW),
        .RTS_THRESH (RTS_THRESH)
    ) dut (
        .clk_bus        (clk_bus),
        .rst_n          (rst_n),
        .divisor        (divisor),
        .cfg_parity_en  (cfg_parity_en),
        .cfg_parity_odd (cfg_parity_odd),
        .cfg_stop2      (cfg_stop2),
        .txdata         (txdata),
        .txbegin        (txbegin),
        .txbusy         (txbusy),
        .rxdata         (rxdata),
        .rx_valid       (rx_valid),
        .data_read      (data_read),
        .rx_count       (rx_count),
        .rx_overrun     (rx_overrun),
        .rx_frame_err   (rx_frame_err),
        .rx_parity_err  (rx_parity_err),
        .err_clr        (err_clr),
        .rx             (rx),
        .tx             (tx),
        .rts            (rts)
    );

    always #5 clk_bus = ~clk_bus;

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers (bounded waits count as comparisons) --
    task automatic tick(input int n);
        repeat (n) @(negedge clk_bus);
    endtask

    task automatic wait_tx_idle(input string name);
        int guard = 0;
        while (txbusy !== 1'b0 && guard < 500) begin
            @(negedge clk_bus);
            guard++;
        end
        checks++;
        if (txbusy !== 1'b0) begin
            failures++;
            $display("FAIL %s_tx_idle_timeout: txbusy=%b required 0 within 500 cycles", name, txbusy);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input string name);
        wait_tx_idle(name);
        txdata  = b;
        txbegin = 1'b1;
        @(negedge clk_bus);
        txbegin = 1'b0;
    endtask

    task automatic wait_count(input int n, input string name);
        int guard = 0;
        while (rx_count !== 5'(n) && guard < 800) begin
            @(negedge clk_bus);
            guard++;
        end
        checks++;
        if (rx_count !== 5'(n)) begin
            failures++;
            $display("FAIL %s_count_timeout: rx_count=%0d required %0d", name, rx_count, n);
        end
    endtask

    task automatic drive_rx_bits(input logic [11:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            rx_drv = bits[i];
            tick(P);
        end
        rx_drv = 1'b1;
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1;
        @(negedge clk_bus);
        err_clr = 1'b0;
    endtask

    // Pop every scoreboard entry from the FIFO and compare it.
    task automatic drain_and_compare(input string name);
        logic [7:0] exp;
        while (sb_q.size() > 0) begin
            exp = sb_q.pop_front();
            checks++;
            if (rx_valid !== 1'b1 || rxdata !== exp) begin
                failures++;
                $display("FAIL %s_rxdata: rx_valid=%b rxdata=%h required valid=1 data=%h", name, rx_valid, rxdata, exp);
            end
            data_read = 1'b1;
            @(negedge clk_bus);
            data_read = 1'b0;
        end
        checks++;
        if (rx_valid !== 1'b0 || rx_count !== 5'd0) begin
            failures++;
            $display("FAIL %s_drained: rx_valid=%b rx_count=%0d required 0/0", name, rx_valid, rx_count);
        end
    endtask

    // ---------------- tests --------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        tick(3);
        checks++;
        if (tx !== 1'b1 || txbusy !== 1'b0 || rts !== 1'b0) begin
            failures++;
            $display("FAIL reset_tx_side: tx=%b txbusy=%b rts=%b required 1/0/0", tx, txbusy, rts);
        end
        checks++;
        if (rx_valid !== 1'b0 || rx_count !== 5'd0 || rxdata !== 8'h00) begin
            failures++;
            $display("FAIL reset_fifo: valid=%b count=%0d data=%h required 0/0/00", rx_valid, rx_count, rxdata);
        end
        checks++;
        if ({rx_overrun, rx_frame_err, rx_parity_err} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags: flags=%b required 000", {rx_overrun, rx_frame_err, rx_parity_err});
        end
        rst_n = 1'b1;
        tick(4);
        checks++;
        if (tx !== 1'b1 || txbusy !== 1'b0 || rx_count !== 5'd0) begin
            failures++;
            $display("FAIL post_reset_idle: tx=%b txbusy=%b count=%0d required 1/0/0", tx, txbusy, rx_count);
        end
    endtask

    // Compare the TX waveform cycle by cycle for 8N1, 8E2 and 8O2 (with a
    // divisor below the clamp), changing the settings mid-frame.
    task automatic test_tx_frames();
        logic [7:0] data;
        logic       pe, odd, s2, par, exp_tx, exp_busy;
        logic [DIV_W-1:0] div;
        int nper, p;
        loop_en = 1'b0;
        rx_drv  = 1'b1;
        data    = 8'hA5;
        for (int c = 0; c < 3; c++) begin
            pe  = (c != 0);
            odd = (c == 2);
            s2  = (c != 0);
            div = (c == 2) ? 16'd0 : 16'd15;
            par = (^data) ^ odd;
            nper = 10 + int'(pe) + int'(s2);
            divisor        = div;
            cfg_parity_en  = pe;
            cfg_parity_odd = odd;
            cfg_stop2      = s2;
            txdata  = data;
            txbegin = 1'b1;
            @(negedge clk_bus);
            txbegin = 1'b0;
            txdata  = 8'h00;
            for (int k = 1; k <= nper * P + 4; k++) begin
                p = (k - 1) / P;
                if (k > nper * P)       exp_tx = 1'b1;
                else if (p == 0)        exp_tx = 1'b0;
                else if (p <= 8)        exp_tx = data[p-1];
                else if (p == 9 && pe)  exp_tx = par;
                else                    exp_tx = 1'b1;
                exp_busy = (k <= nper * P);
                checks++;
                if (tx !== exp_tx || txbusy !== exp_busy) begin
                    failures++;
                    $display("FAIL tx_frame%0d_cycle%0d: tx=%b txbusy=%b required %b/%b", c, k, tx, txbusy, exp_tx, exp_busy);
                end
                if (k == 40) begin
                    divisor        = 16'd40;
                    cfg_parity_en  = ~pe;
                    cfg_stop2      = ~s2;
                    cfg_parity_odd = ~odd;
                end
                @(negedge clk_bus);
            end
        end
        divisor        = 16'd15;
        cfg_parity_en  = 1'b0;
        cfg_parity_odd = 1'b0;
        cfg_stop2      = 1'b0;
    endtask

    task automatic test_loopback();
        logic [7:0] bytes [3];
        bytes[0] = 8'h00;
        bytes[1] = 8'hFF;
        bytes[2] = 8'h3C;
        loop_en = 1'b1;
        sb_q.delete();
        for (int i = 0; i < 3; i++) begin
            send_byte(bytes[i], "loopback");
            sb_q.push_back(bytes[i]);
        end
        wait_tx_idle("loopback");
        wait_count(3, "loopback");
        checks++;
        if (rx_count !== 5'd3 || rx_valid !== 1'b1) begin
            failures++;
            $display("FAIL loopback_count: rx_count=%0d valid=%b required 3/1", rx_count, rx_valid);
        end
        drain_and_compare("loopback");
        // A pop on an empty FIFO is ignored.
        data_read = 1'b1;
        @(negedge clk_bus);
        data_read = 1'b0;
        tick(1);
        checks++;
        if (rx_count !== 5'd0 || rx_valid !== 1'b0 || rxdata !== 8'h00) begin
            failures++;
            $display("FAIL empty_read: count=%0d valid=%b data=%h required 0/0/00", rx_count, rx_valid, rxdata);
        end
    endtask

    task automatic test_overrun_rts();
        logic [7:0] b;
        int exp_cnt;
        loop_en = 1'b1;
        sb_q.delete();
        for (int i = 1; i <= 17; i++) begin
            b = 8'(i * 13 + 7);
            send_byte(b, "overrun");
            if (i <= DEPTH) sb_q.push_back(b);
            if (i == RTS_THRESH) begin
                wait_count(RTS_THRESH, "rts");
                checks++;
                if (rts !== 1'b0) begin
                    failures++;
                    $display("FAIL rts_registered: rts=%b in the count-change cycle, required 0", rts);
                end
                @(negedge clk_bus);
                checks++;
                if (rts !== 1'b1) begin
                    failures++;
                    $display("FAIL rts_rise: rts=%b one cycle after count=12, required 1", rts);
                end
            end
            wait_tx_idle("overrun");
            exp_cnt = (i < DEPTH) ? i : DEPTH;
            checks++;
            if (rx_count !== 5'(exp_cnt) || rx_overrun !== (i == 17) || rts !== (exp_cnt >= RTS_THRESH)) begin
                failures++;
                $display("FAIL fill_byte%0d: count=%0d overrun=%b rts=%b required %0d/%b/%b",
                         i, rx_count, rx_overrun, rts, exp_cnt, (i == 17), (exp_cnt >= RTS_THRESH));
            end
        end
        pulse_err_clr();
        checks++;
        if (rx_overrun !== 1'b0 || rx_count !== 5'd16) begin
            failures++;
            $display("FAIL overrun_clear: overrun=%b count=%0d required 0/16", rx_overrun, rx_count);
        end
        drain_and_compare("overrun");
        tick(1);
        checks++;
        if (rts !== 1'b0) begin
            failures++;
            $display("FAIL rts_fall: rts=%b after drain, required 0", rts);
        end
    endtask

    task automatic test_rx_errors();
        logic [11:0] bits;
        logic [7:0]  d;
        loop_en = 1'b0;
        rx_drv  = 1'b1;
        divisor = 16'd15;
        d = 8'h5A;
        sb_q.delete();
        tick(4);
        // 4-cycle glitch: the start bit votes 1, so nothing happens.
        rx_drv = 1'b0;
        tick(4);
        rx_drv = 1'b1;
        tick(40);
        checks++;
        if (rx_count !== 5'd0 || {rx_overrun, rx_frame_err, rx_parity_err} !== 3'b000) begin
            failures++;
            $display("FAIL glitch: count=%0d flags=%b required 0/000", rx_count, {rx_overrun, rx_frame_err, rx_parity_err});
        end
        // Stop bit forced low.
        bits = {2'b11, 1'b0, d, 1'b0};
        drive_rx_bits(bits, 10);
        tick(20);
        checks++;
        if (rx_frame_err !== 1'b1 || rx_count !== 5'd0 || rx_parity_err !== 1'b0) begin
            failures++;
            $display("FAIL frame_err: frame_err=%b count=%0d parity_err=%b required 1/0/0", rx_frame_err, rx_count, rx_parity_err);
        end
        pulse_err_clr();
        checks++;
        if (rx_frame_err !== 1'b0) begin
            failures++;
            $display("FAIL frame_err_clear: frame_err=%b required 0", rx_frame_err);
        end
        // Even parity, correct parity bit.
        cfg_parity_en  = 1'b1;
        cfg_parity_odd = 1'b0;
        bits = {1'b1, 1'b1, ^d, d, 1'b0};
        drive_rx_bits(bits, 11);
        sb_q.push_back(d);
        tick(20);
        checks++;
        if (rx_parity_err !== 1'b0 || rx_count !== 5'd1) begin
            failures++;
            $display("FAIL parity_good: parity_err=%b count=%0d required 0/1", rx_parity_err, rx_count);
        end
        // Even parity, flipped parity bit: flag set, byte still pushed.
        d = 8'h81;
        bits = {1'b1, 1'b1, ~(^d), d, 1'b0};
        drive_rx_bits(bits, 11);
        sb_q.push_back(d);
        tick(20);
        checks++;
        if (rx_parity_err !== 1'b1 || rx_count !== 5'd2 || rx_frame_err !== 1'b0) begin
            failures++;
            $display("FAIL parity_bad: parity_err=%b count=%0d frame_err=%b required 1/2/0", rx_parity_err, rx_count, rx_frame_err);
        end
        drain_and_compare("parity");
        pulse_err_clr();
        cfg_parity_en = 1'b0;
    endtask

    task automatic test_reset_midframe();
        loop_en = 1'b1;
        sb_q.delete();
        send_byte(8'h11, "pre_reset");
        wait_tx_idle("pre_reset");
        wait_count(1, "pre_reset");
        send_byte(8'h96, "mid_reset");
        tick(50);
        rst_n = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b1 || txbusy !== 1'b0 || rx_count !== 5'd0 || rx_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_midframe: tx=%b busy=%b count=%0d valid=%b required 1/0/0/0", tx, txbusy, rx_count, rx_valid);
        end
        tick(3);
        rst_n = 1'b1;
        tick(3);
        send_byte(8'hC3, "post_reset");
        sb_q.push_back(8'hC3);
        wait_tx_idle("post_reset");
        wait_count(1, "post_reset");
        checks++;
        if ({rx_overrun, rx_frame_err, rx_parity_err} !== 3'b000) begin
            failures++;
            $display("FAIL post_reset_flags: flags=%b required 000", {rx_overrun, rx_frame_err, rx_parity_err});
        end
        drain_and_compare("post_reset");
    endtask

    initial begin
        test_reset();
        test_tx_frames();
        test_loopback();
        test_overrun_rts();
        test_rx_errors();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_fifo.md
Name: uart_fifo

Overview:
- Next-generation serial port for the bus side of the machine. Replaces fixed-clock/fixed-baud UARTs with a runtime baud divisor, selectable parity and stop-bit count, and a receive FIFO with level-based RTS.
- Sits between the CPU port decoder and the RS232 pins.
- One transmit holding stage; received bytes queue in the FIFO until the CPU reads them.

Parameters:
DIV_W, 16, width of the baud divisor input
FIFO_AW, 4, RX FIFO address width; depth = 2**FIFO_AW (16)
RTS_THRESH, 12, FIFO fill level at or above which rts asserts; must be < 2**FIFO_AW

Ports:
clk_bus  in  1  system clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
divisor  in  DIV_W  bit period minus one, in clk_bus cycles; values < 15 treated as 15
cfg_parity_en  in  1  1 = parity bit after data
cfg_parity_odd  in  1  1 = odd parity, 0 = even
cfg_stop2  in  1  1 = two stop bits (TX only; RX checks first stop bit)
txdata  in  8  byte to send
txbegin  in  1  send request, level-sampled
txbusy  out  1  transmitter busy
rxdata  out  8  FIFO head (first-word fall-through)
rx_valid  out  1  FIFO not empty
data_read  in  1  one-cycle pop strobe
rx_count  out  FIFO_AW+1  FIFO fill level
rx_overrun  out  1  sticky: byte lost because FIFO full
rx_frame_err  out  1  sticky: stop bit sampled 0
rx_parity_err  out  1  sticky: parity mismatch
err_clr  in  1  clears all three sticky flags
rx  in  1  serial input, asynchronous
tx  out  1  serial output
rts  out  1  1 = peer must pause

Behaviour:
- Reset values: tx=1, txbusy=0, rx_valid=0, rx_count=0, rxdata=0, all error flags 0, rts=0. FIFO is emptied. Both FSMs go to IDLE. Reset mid-frame aborts the frame immediately; tx returns high.
- Bit period: P = max(divisor,15)+1 cycles. divisor and cfg_* are latched at frame start (TX on accept, RX on start detect). Changes mid-frame do not affect that frame.
- TX FSM (IDLE, START, DATA, PARITY, STOP):
  - Accept when txbegin=1 and txbusy=0 in IDLE. In the accept cycle, latch txdata; txbusy=1 from the next cycle.
  - tx goes low on the cycle after accept.
  - Each state lasts P cycles. Data goes out LSB first. PARITY state only if enabled; the parity bit is the XOR of the data, inverted when odd. STOP lasts P, or 2P when cfg_stop2.
  - txbusy falls on the cycle after the last stop cycle; back-to-back frames are allowed from that cycle.
  - txbegin held high while busy is ignored; no edge requirement.
- RX input path: two-flop synchroniser on rx.
- RX FSM (IDLE, START, DATA, PARITY, STOP):
  - Start detect: synchronised 1->0 transition while in IDLE.
  - Each bit is evaluated by majority vote of three samples at counter offsets (P/2)-1, P/2, (P/2)+1 from the bit's start.
  - Start bit voting 1 = glitch: return to IDLE, no flags, no push.
  - After the first stop bit is evaluated, FSM returns to IDLE immediately (mid-stop), so the next start edge is caught.
  - Stop voted 0: set rx_frame_err, discard byte.
  - Parity mismatch: set rx_parity_err, byte still pushed.
- FIFO:
  - Push at stop-bit evaluation if FIFO not full. If full, drop the byte and set rx_overrun.
  - data_read while empty is ignored.
  - Simultaneous push and pop: both succeed, rx_count unchanged, no overrun even when full.
  - rxdata/rx_valid reflect the new head the cycle after a pop.
  - Pointers wrap modulo depth; rx_count ranges 0..2**FIFO_AW.
- rts = (rx_count >= RTS_THRESH), registered, one cycle after the count change.
- err_clr: clears flags next cycle. An error event in the same cycle as err_clr wins; the flag is set.

Test Plan:
- divisor=15, 8N1, txbegin pulse with txdata=0xA5 -> tx low for cycles 1-16, then bits 1,0,1,0,0,1,0,1 each 16 cycles, then high 16 cycles; txbusy high for exactly 160 cycles.
- Parity even then odd, 0xA5 (four 1s), cfg_stop2=1 -> parity bit 0 then 1; frame 12 bit periods (192 cycles); txbusy pattern matches.
- Loop tx to rx, send 0x00, 0xFF, 0x3C -> FIFO holds 3 bytes in order; rx_count=3; three data_read pulses return them and rx_valid drops after the third.
- Send 17 bytes with no reads (depth 16, RTS_THRESH=12) -> rts rises when rx_count reaches 12; 17th byte dropped, rx_overrun=1, rx_count=16; err_clr clears the flag.
- Drive a 4-cycle low glitch on rx -> no push, no flags. Frame with stop bit forced 0 -> rx_frame_err=1, rx_count unchanged. Even-parity frame with parity bit flipped -> rx_parity_err=1, byte pushed.
- Assert rst_n low mid-TX and mid-RX -> tx=1, txbusy=0, FIFO empty immediately; next full frame transmits and receives correctly.
